// File: rtl/fft_pkg.sv
// Shared constants for the fixed-point radix-2 butterfly: default word format,
// FSM state encoding and saturation limits.
package fft_pkg;

    localparam int FFT_N = 16;
    localparam int FFT_Q = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ADD  = 2'd2,
        ST_OUT  = 2'd3
    } fft_state_t;

    function automatic longint sat_max_of(input int n);
        return (64'sd1 <<< (n - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min_of(input int n);
        return -(64'sd1 <<< (n - 1));
    endfunction

    localparam longint SAT_MAX = sat_max_of(FFT_N);
    localparam longint SAT_MIN = sat_min_of(FFT_N);

endpackage

// File: rtl/fxp_mul.sv
// Signed fixed-point multiply: full 2N-bit product, arithmetic shift by Q,
// wrap to N bits (no saturation; rounds toward minus infinity).
module fxp_mul
    import fft_pkg::*;
#(
    parameter int N = FFT_N,
    parameter int Q = FFT_Q
) (
    input  logic signed [N-1:0] i_a,
    input  logic signed [N-1:0] i_b,
    output logic signed [N-1:0] o_p
);

    logic signed [2*N-1:0] full;

    assign full = i_a * i_b;
    assign o_p  = N'(full >>> Q);

endmodule

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly X = A + B*W, Y = A - B*W, one operand set per four
// cycles through IDLE -> MUL -> ADD -> OUT with valid/ready on both sides.
module fft_butterfly
    import fft_pkg::*;
#(
    parameter int N = FFT_N,
    parameter int Q = FFT_Q
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic signed [N-1:0] i_a_re,
    input  logic signed [N-1:0] i_a_im,
    input  logic signed [N-1:0] i_b_re,
    input  logic signed [N-1:0] i_b_im,
    input  logic signed [N-1:0] i_w_re,
    input  logic signed [N-1:0] i_w_im,
    output logic               o_valid,
    input  logic               i_ready,
    output logic signed [N-1:0] o_x_re,
    output logic signed [N-1:0] o_x_im,
    output logic signed [N-1:0] o_y_re,
    output logic signed [N-1:0] o_y_im,
    output fft_state_t         o_state
);

    // Handshake: a set moves on a rising edge where valid && ready are both 1.
    // o_ready is high only in IDLE, o_valid only in OUT; both are registered.

    localparam longint SAT_HI = (N == FFT_N) ? SAT_MAX : sat_max_of(N);
    localparam longint SAT_LO = (N == FFT_N) ? SAT_MIN : sat_min_of(N);
    localparam logic signed [N:0] HI_EXT = (N+1)'(SAT_HI);
    localparam logic signed [N:0] LO_EXT = (N+1)'(SAT_LO);

    fft_state_t state;

    logic signed [N-1:0] a_re_q, a_im_q, b_re_q, b_im_q, w_re_q, w_im_q;
    logic signed [N-1:0] prod_rr, prod_ii, prod_ri, prod_ir;
    logic signed [N-1:0] m_rr, m_ii, m_ri, m_ir;
    logic signed [N-1:0] p_re, p_im, x_re_d, x_im_d, y_re_d, y_im_d;

    function automatic logic signed [N-1:0] sat(input logic signed [N:0] s);
        if (s > HI_EXT)      return HI_EXT[N-1:0];
        else if (s < LO_EXT) return LO_EXT[N-1:0];
        else                 return s[N-1:0];
    endfunction

    function automatic logic signed [N-1:0] add_sat(input logic signed [N-1:0] a,
                                                    input logic signed [N-1:0] b);
        logic signed [N:0] s;
        s = $signed({a[N-1], a}) + $signed({b[N-1], b});
        return sat(s);
    endfunction

    function automatic logic signed [N-1:0] sub_sat(input logic signed [N-1:0] a,
                                                    input logic signed [N-1:0] b);
        logic signed [N:0] s;
        s = $signed({a[N-1], a}) - $signed({b[N-1], b});
        return sat(s);
    endfunction

    fxp_mul #(.N(N), .Q(Q)) u_mul_rr (.i_a(b_re_q), .i_b(w_re_q), .o_p(m_rr));
    fxp_mul #(.N(N), .Q(Q)) u_mul_ii (.i_a(b_im_q), .i_b(w_im_q), .o_p(m_ii));
    fxp_mul #(.N(N), .Q(Q)) u_mul_ri (.i_a(b_re_q), .i_b(w_im_q), .o_p(m_ri));
    fxp_mul #(.N(N), .Q(Q)) u_mul_ir (.i_a(b_im_q), .i_b(w_re_q), .o_p(m_ir));

    // B*W is saturated before it is added to or subtracted from A.
    always_comb begin
        p_re   = sub_sat(prod_rr, prod_ii);
        p_im   = add_sat(prod_ri, prod_ir);
        x_re_d = add_sat(a_re_q, p_re);
        x_im_d = add_sat(a_im_q, p_im);
        y_re_d = sub_sat(a_re_q, p_re);
        y_im_d = sub_sat(a_im_q, p_im);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            a_re_q  <= '0;
            a_im_q  <= '0;
            b_re_q  <= '0;
            b_im_q  <= '0;
            w_re_q  <= '0;
            w_im_q  <= '0;
            prod_rr <= '0;
            prod_ii <= '0;
            prod_ri <= '0;
            prod_ir <= '0;
            o_x_re  <= '0;
            o_x_im  <= '0;
            o_y_re  <= '0;
            o_y_im  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_valid) begin
                        a_re_q  <= i_a_re;
                        a_im_q  <= i_a_im;
                        b_re_q  <= i_b_re;
                        b_im_q  <= i_b_im;
                        w_re_q  <= i_w_re;
                        w_im_q  <= i_w_im;
                        o_ready <= 1'b0;
                        state   <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    prod_rr <= m_rr;
                    prod_ii <= m_ii;
                    prod_ri <= m_ri;
                    prod_ir <= m_ir;
                    state   <= ST_ADD;
                end
                ST_ADD: begin
                    o_x_re  <= x_re_d;
                    o_x_im  <= x_im_d;
                    o_y_re  <= y_re_d;
                    o_y_im  <= y_im_d;
                    o_valid <= 1'b1;
                    state   <= ST_OUT;
                end
                ST_OUT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_fft_butterfly.sv
// Directed bench for fft_butterfly: arithmetic model with an expected queue,
// latency/backpressure/reset checks and literal expectations for key vectors.
module tb_fft_butterfly;
    import fft_pkg::*;

    localparam int N = FFT_N;
    localparam int Q = FFT_Q;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_valid = 1'b0;
    logic i_ready = 1'b1;
    logic o_ready, o_valid;
    logic signed [N-1:0] i_a_re = '0, i_a_im = '0, i_b_re = '0, i_b_im = '0;
    logic signed [N-1:0] i_w_re = '0, i_w_im = '0;
    logic signed [N-1:0] o_x_re, o_x_im, o_y_re, o_y_im;
    fft_state_t o_state;

    int checks = 0;
    int errors = 0;
    logic [4*N-1:0] exp_q[$];

    fft_butterfly #(.N(N), .Q(Q)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_a_re(i_a_re), .i_a_im(i_a_im), .i_b_re(i_b_re), .i_b_im(i_b_im),
        .i_w_re(i_w_re), .i_w_im(i_w_im), .o_valid(o_valid), .i_ready(i_ready),
        .o_x_re(o_x_re), .o_x_im(o_x_im), .o_y_re(o_y_re), .o_y_im(o_y_im),
        .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic longint wrap_n(input longint v);
        longint m;
        m = v & ((64'sd1 <<< N) - 1);
        if (m >= (64'sd1 <<< (N - 1))) m = m - (64'sd1 <<< N);
        return m;
    endfunction

    function automatic longint clamp(input longint v);
        if (v > SAT_MAX) return SAT_MAX;
        if (v < SAT_MIN) return SAT_MIN;
        return v;
    endfunction

    function automatic longint fx_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return wrap_n(p >>> Q);
    endfunction

    // X = A + B*W, Y = A - B*W with truncating products and saturating sums.
    function automatic logic [4*N-1:0] model(input logic [N-1:0] ar, ai, br, bi, wr, wi);
        longint pre, pim, xr, xi, yr, yi;
        pre = clamp(fx_mul(br, wr) - fx_mul(bi, wi));
        pim = clamp(fx_mul(br, wi) + fx_mul(bi, wr));
        xr = clamp(longint'($signed(ar)) + pre);
        xi = clamp(longint'($signed(ai)) + pim);
        yr = clamp(longint'($signed(ar)) - pre);
        yi = clamp(longint'($signed(ai)) - pim);
        return {N'(xr), N'(xi), N'(yr), N'(yi)};
    endfunction

    // Compare process: every cycle with o_valid high, outputs must match the
    // head of the expected queue; the entry retires when the result transfers.
    always @(negedge i_clk) begin
        if (!i_rst && o_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 64'(o_valid), 64'(0));
            end else begin
                chk("result", 64'({o_x_re, o_x_im, o_y_re, o_y_im}), 64'(exp_q[0]));
                if (i_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [N-1:0] ar, ai, br, bi, wr, wi,
                        input int hold, input bit lit, input logic [4*N-1:0] lit_val);
        logic [4*N-1:0] snap;
        int waited = 0;
        while (!o_ready && waited < 20) begin
            @(posedge i_clk); #1;
            waited++;
        end
        if (!o_ready) begin
            chk("ready_timeout", 64'(o_ready), 64'(1));
            return;
        end
        i_a_re = ar; i_a_im = ai; i_b_re = br; i_b_im = bi; i_w_re = wr; i_w_im = wi;
        i_valid = 1'b1;
        i_ready = (hold == 0);
        exp_q.push_back(model(ar, ai, br, bi, wr, wi));
        @(posedge i_clk); #1;
        chk("state_after_accept", 64'(o_state), 64'(ST_MUL));
        chk("ready_in_mul", 64'(o_ready), 64'(0));
        // keep i_valid high with junk data while busy; it must be ignored
        i_a_re = ~ar; i_b_re = ~br; i_w_im = ~wi;
        @(posedge i_clk); #1;
        chk("valid_latency_2", 64'(o_valid), 64'(0));
        chk("ready_in_add", 64'(o_ready), 64'(0));
        @(posedge i_clk); #1;
        chk("valid_latency_3", 64'(o_valid), 64'(1));
        chk("ready_in_out", 64'(o_ready), 64'(0));
        i_valid = 1'b0;
        if (lit) chk("literal", 64'({o_x_re, o_x_im, o_y_re, o_y_im}), 64'(lit_val));
        if (hold > 0) begin
            snap = {o_x_re, o_x_im, o_y_re, o_y_im};
            repeat (hold) begin
                @(posedge i_clk); #1;
                chk("hold_stable", 64'({o_x_re, o_x_im, o_y_re, o_y_im}), 64'(snap));
                chk("hold_valid", 64'(o_valid), 64'(1));
                chk("hold_ready", 64'(o_ready), 64'(0));
            end
            i_ready = 1'b1;
        end
        @(posedge i_clk); #1;
        chk("valid_after_xfer", 64'(o_valid), 64'(0));
        chk("ready_after_xfer", 64'(o_ready), 64'(1));
        chk("idle_after_xfer", 64'(o_state), 64'(ST_IDLE));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        chk("valid_in_reset", 64'(o_valid), 64'(0));
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        chk("reset_ready", 64'(o_ready), 64'(1));
        chk("reset_valid", 64'(o_valid), 64'(0));
        chk("reset_outputs", 64'({o_x_re, o_x_im, o_y_re, o_y_im}), 64'(0));

        send(16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 0, 1'b1,
             64'h0200_0000_0000_0000);
        send(16'h0100, 16'h0000, 16'h0100, 16'h0000, 16'h0000, 16'hFF00, 0, 1'b1,
             64'h0100_FF00_0100_0100);
        send(16'h7F00, 16'h0000, 16'h0100, 16'h0000, 16'h0100, 16'h0000, 0, 1'b1,
             64'h7FFF_0000_7E00_0000);
        send(16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0080, 16'h0000, 0, 1'b1,
             64'hFFFF_0000_0001_0000);
        // P saturates before the second add: P = (0x7FFF, 0)
        send(16'h4000, 16'hC000, 16'h7F00, 16'h8100, 16'h0100, 16'h0100, 0, 1'b1,
             64'h7FFF_C000_C001_C000);
        // negative saturation of Y
        send(16'h8000, 16'h8000, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 0, 1'b1,
             64'h8100_8100_8000_8000);
        send(16'h0123, 16'hFE00, 16'h0300, 16'h0180, 16'h00B5, 16'hFF4B, 0, 1'b0, '0);
        send(16'h0080, 16'h0040, 16'h0200, 16'hFF00, 16'h0100, 16'h0100, 5, 1'b0, '0);

        // reset while the set is in MUL: the set must vanish
        i_a_re = 16'h1234; i_a_im = 16'h0101; i_b_re = 16'h0200; i_b_im = 16'h0300;
        i_w_re = 16'h0100; i_w_im = 16'h0100;
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        chk("rst_test_in_mul", 64'(o_state), 64'(ST_MUL));
        i_valid = 1'b0;
        i_rst = 1'b1;
        #1;
        chk("rst_async_valid", 64'(o_valid), 64'(0));
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (8) begin
            @(posedge i_clk); #1;
            chk("rst_no_valid", 64'(o_valid), 64'(0));
        end
        chk("rst_ready", 64'(o_ready), 64'(1));
        chk("rst_outputs_zero", 64'({o_x_re, o_x_im, o_y_re, o_y_im}), 64'(0));
        chk("exp_queue_drained", 64'(exp_q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
